// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   - state_e       : FSM state encoding (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH : default operand/result width
//   - DEFAULT_CNT_W : bit-counter width for the default operand width
//   - cnt_width()   : bit-counter width for an arbitrary operand width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The counter must reach w-1. Clamp to one bit so that a degenerate
  // width still yields a legal vector.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_adder.sv
// ---------------------------------------------------------------------------
// adder
//   1-bit full-adder cell, purely combinational.
//   Ports:
//     a, b  : operand bits
//     Cin   : carry in
//     S     : sum bit
//     Cout  : carry out
// ---------------------------------------------------------------------------
module adder (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic p;

  assign p    = a ^ b;
  assign S    = p ^ Cin;
  assign Cout = (a & b) | (Cin & p);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
//   processed LSB first through one full-adder cell with a registered carry,
//   and the assembled result is published with a one-cycle done strobe.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, a 'sub' input selects A - B. The B register then loads
//     ~b and the carry flop loads 1, so cin is ignored for subtraction.
//
//   Handshake: 'start' is a request that is only accepted while the FSM is
//   in IDLE; a start seen in SHIFT or DONE is dropped, never queued. 'done'
//   is a single-cycle strobe with no back-pressure; sum/cout stay stable
//   until the next done.
//
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     start     : request, accepted only in IDLE
//     a, b      : operands, sampled on the accepting edge
//     cin       : carry in, sampled on the accepting edge
//     sub       : (SERIAL_ADDER_SUB_EN only) 1 selects subtraction
//     busy      : high while bits are being processed
//     done      : one-cycle pulse, sum/cout valid
//     sum       : result, held until the next done
//     cout      : final carry-out, held until the next done
//     state_dbg : current FSM state, for observation only
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_e           state_dbg
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               accept;
  logic               last_bit;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   sum_sh_d;

  assign accept   = (state_q == ST_IDLE) && start;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);

  // Subtraction is A + ~B + 1: invert B on load and force the carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= a;
      b_sh_q   <= b_load;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= carry_load;
    end else if (state_q == ST_SHIFT) begin
      a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_q + CNT_W'(1);
      carry_q  <= fa_cout;
    end
  end

  // Published result changes only on the edge that processes the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (last_bit) begin
      sum_q  <= sum_sh_d;
      cout_q <= fa_cout;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  state_e       state_dbg;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    int r;
    if (ms) begin
      r = (int'(ma) - int'(mb)) & ((1 << W) - 1);
      return {(ma >= mb), r[W-1:0]};
    end
    r = int'(ma) + int'(mb) + int'(mc);
    return r[W:0];
  endfunction

  task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic vs, input logic [W-1:0] vsum, input logic vcout);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.sum = vsum; v.cout = vcout;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle = from #1 after one rising edge to #1 after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle (cycle 0). Checks busy in cycles 1..W, the done
  // cycle W+1, and that the result is held in cycle W+2.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input logic [W:0] expv, input string tag);
    logic [W:0] e;
    exp_q.push_back(expv);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    step();
    start = 1'b0;
    // Operands changing after acceptance must not matter.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    for (int i = 1; i <= W; i++) begin
      check({tag, " busy/done in shift"}, 32'({busy, done}), 32'(2'b10));
      step();
    end
    e = exp_q.pop_front();
    check({tag, " busy/done at done"}, 32'({busy, done}), 32'(2'b01));
    check({tag, " sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, " cout"}, 32'(cout), 32'(e[W]));
    step();
    check({tag, " done dropped"}, 32'({busy, done}), 32'(2'b00));
    check({tag, " result held"}, 32'({cout, sum}), 32'(e));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (state_dbg == ST_IDLE) break;
      step();
    end
    check({tag, " reached idle"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test ----------------
  initial begin
    int n_done;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    // Reset state
    #2;
    check("reset outputs", 32'({busy, done, cout, sum}), 32'(0));
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed vector table
    add_vec(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
    add_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    add_vec(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
    add_vec(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    add_vec(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
    add_vec(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0);
    add_vec(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    add_vec(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    add_vec(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    add_vec(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    add_vec(8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1);
    add_vec(8'h00, 8'hFF, 1'b1, 1'b1, 8'h01, 1'b0);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));
    end

    // Starts during SHIFT and during DONE are ignored
    exp_q.push_back({1'b0, 8'h30});
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();                                   // cycle 1
    start = 1'b0;
    step(); step(); step();                   // cycle 4
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();                                   // cycle 5
    start = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      check("ignore busy in shift", 32'(busy), 32'(1));
      step();
    end
    begin
      logic [W:0] e;
      e = exp_q.pop_front();
      check("ignore done", 32'(done), 32'(1));
      check("ignore result", 32'({cout, sum}), 32'(e));
    end
    start = 1'b1;                             // start during DONE
    step();                                   // cycle 10
    start = 1'b0;
    check("ignore done-cycle start", 32'(busy), 32'(0));
    n_done = 0;
    for (int c = 10; c < 24; c++) begin
      if (done) n_done++;
      step();
    end
    check("ignore no second done", 32'(n_done), 32'(0));
    check("ignore result kept", 32'({cout, sum}), 32'({1'b0, 8'h30}));

    // Continuous start: one result every W+2 cycles
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 35; c++) begin
      step();
      if (done) begin
        n_done++;
        check("cont done spacing", 32'(c % (W + 2)), 32'(W + 1));
        check("cont sum", 32'({cout, sum}), 32'({1'b0, 8'h02}));
      end
    end
    start = 1'b0;
    check("cont done count", 32'(n_done), 32'(3));
    wait_idle("cont");

    // Reset in the middle of an operation
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();       // cycle 5
    check("midreset busy before", 32'(busy), 32'(1));
    check("midreset old result held", 32'({cout, sum}), 32'({1'b0, 8'h02}));
    rst_n = 1'b0;
    #1;
    check("midreset outputs", 32'({busy, done, cout, sum}), 32'(0));
    check("midreset state", 32'(state_dbg), 32'(ST_IDLE));
    step(); step();
    rst_n = 1'b1;
    step();
    run_op(8'h03, 8'h04, 1'b0, 1'b0, {1'b0, 8'h07}, "after reset");

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(255, 0));
      rc = 1'($urandom_range(1, 0));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      if (i == 0) begin ra = 8'hFF; rb = 8'h00; rc = 1'b1; end
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
